// File: rtl/lifo_reverser_pkg.sv
// Shared constants and FSM encoding for the LIFO frame reverser.
package lifo_reverser_pkg;

    localparam int DEFAULT_DATA_BITS    = 8;
    localparam int DEFAULT_ADDRESS_BITS = 4;

    // FILL accepts input beats, DRAIN emits them in reverse order.
    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/lifo_reverser_if.sv
// Streaming handshake bundle: producer side (in_*) and consumer side (out_*).
// master = the environment driving beats in and accepting beats out;
// slave  = the reverser itself.
interface lifo_reverser_if
    import lifo_reverser_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS
);

    logic                 in_valid;
    logic [DATA_BITS-1:0] in_data;
    logic                 in_last;
    logic                 in_ready;
    logic                 out_valid;
    logic [DATA_BITS-1:0] out_data;
    logic                 out_last;
    logic                 out_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

endinterface

// File: rtl/lifo_store.sv
// Stack storage for one frame: push writes at the stack pointer, pop moves it
// back, and the top entry is read combinationally from the registered pointer.
module lifo_store
    import lifo_reverser_pkg::*;
#(
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int ADDRESS_BITS = DEFAULT_ADDRESS_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [DATA_BITS-1:0]  push_data_i,
    input  logic                  pop_i,
    output logic [DATA_BITS-1:0]  top_data_o,
    output logic [ADDRESS_BITS:0] count_o
);

    localparam int DEPTH = 2 ** ADDRESS_BITS;
    localparam logic [ADDRESS_BITS:0]   CNT_ONE = (ADDRESS_BITS + 1)'(1);
    localparam logic [ADDRESS_BITS-1:0] IDX_ONE = ADDRESS_BITS'(1);

    logic [DATA_BITS-1:0]    mem_q [DEPTH];
    logic [ADDRESS_BITS:0]   sp_q;
    logic [ADDRESS_BITS:0]   sp_d;
    logic [ADDRESS_BITS-1:0] rd_idx;

    // Pointer next-state: push and pop are mutually exclusive at the caller.
    always_comb begin
        sp_d = sp_q;
        if (push_i) begin
            sp_d = sp_q + CNT_ONE;
        end else if (pop_i) begin
            sp_d = sp_q - CNT_ONE;
        end
    end

    // Stack pointer doubles as the occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Storage is deliberately not reset; it is unobservable while empty.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[sp_q[ADDRESS_BITS-1:0]] <= push_data_i;
        end
    end

    // Top of stack is entry sp-1; the low-bit wrap maps a full pointer to DEPTH-1.
    assign rd_idx     = sp_q[ADDRESS_BITS-1:0] - IDX_ONE;
    assign top_data_o = mem_q[rd_idx];
    assign count_o    = sp_q;

endmodule

// File: rtl/lifo_reverser.sv
// Frame reverser: collects a frame (up to 2**ADDRESS_BITS beats) in FILL, then
// replays it last-beat-first in DRAIN. Over-long frames are cut at full depth
// with a one-cycle overflow pulse; the remainder starts a new frame.
module lifo_reverser
    import lifo_reverser_pkg::*;
#(
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int ADDRESS_BITS = DEFAULT_ADDRESS_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    lifo_reverser_if.slave        bus,
    output logic                  overflow,
    output logic [7:0]            frame_count
);

    localparam int DEPTH = 2 ** ADDRESS_BITS;
    localparam logic [ADDRESS_BITS:0] CNT_ONE       = (ADDRESS_BITS + 1)'(1);
    localparam logic [ADDRESS_BITS:0] CNT_NEAR_FULL = (ADDRESS_BITS + 1)'(DEPTH - 1);

    state_t                state_q;
    logic                  overflow_q;
    logic [7:0]            frame_count_q;
    logic [ADDRESS_BITS:0] count;
    logic                  push;
    logic                  pop;
    logic                  last_out;

    // Handshake outputs derive only from registered state (and reset for in_ready).
    assign bus.in_ready  = (state_q == FILL) && !reset;
    assign bus.out_valid = (state_q == DRAIN);
    assign last_out      = (state_q == DRAIN) && (count == CNT_ONE);
    assign bus.out_last  = last_out;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    lifo_store #(
        .DATA_BITS    (DATA_BITS),
        .ADDRESS_BITS (ADDRESS_BITS)
    ) u_store (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (bus.in_data),
        .pop_i       (pop),
        .top_data_o  (bus.out_data),
        .count_o     (count)
    );

    // FSM with registered overflow pulse and completed-frame counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FILL;
            overflow_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            overflow_q <= 1'b0;
            case (state_q)
                FILL: begin
                    if (push) begin
                        if (bus.in_last) begin
                            state_q <= DRAIN;
                        end else if (count == CNT_NEAR_FULL) begin
                            state_q    <= DRAIN;
                            overflow_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && last_out) begin
                        state_q       <= FILL;
                        frame_count_q <= frame_count_q + 8'd1;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign overflow    = overflow_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_lifo_reverser.sv
// Directed bench for lifo_reverser: each task drives one scenario and checks
// outputs one time unit after the rising edge.
module tb_lifo_reverser;

    logic       clk;
    logic       reset;
    logic       overflow;
    logic [7:0] frame_count;
    int         n_checks;
    int         n_fail;

    lifo_reverser_if #(.DATA_BITS(8)) bus ();

    lifo_reverser #(
        .DATA_BITS    (8),
        .ADDRESS_BITS (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until accepted (bounded).
    task automatic push_beat(input logic [7:0] d, input logic last);
        int unsigned waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        if (waited >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout data=%h got in_ready=%b exp=1", d, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        n_checks++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last got=%b exp=0", bus.out_last); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
        n_checks++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL rst_frame_count got=%0d exp=0", frame_count); end
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_basic();
        logic [7:0] exp_d [3];
        exp_d = '{8'h33, 8'h22, 8'h11};
        bus.out_ready = 1'b1;
        push_beat(8'h11, 1'b0);
        push_beat(8'h22, 1'b0);
        push_beat(8'h33, 1'b1);
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready got=%b exp=0", bus.in_ready); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid%0d got=%b exp=1", i, bus.out_valid); end
            n_checks++; if (bus.out_data !== exp_d[i]) begin n_fail++; $display("FAIL basic_data%0d got=%h exp=%h", i, bus.out_data, exp_d[i]); end
            n_checks++; if (bus.out_last !== (i == 2)) begin n_fail++; $display("FAIL basic_last%0d got=%b exp=%b", i, bus.out_last, (i == 2)); end
            tick();
        end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_end_valid got=%b exp=0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_end_ready got=%b exp=1", bus.in_ready); end
        n_checks++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL basic_frame_count got=%0d exp=1", frame_count); end
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        push_beat(8'hA5, 1'b1);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", bus.out_valid); end
        n_checks++; if (bus.out_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got=%h exp=a5", bus.out_data); end
        n_checks++; if (bus.out_last !== 1'b1) begin n_fail++; $display("FAIL single_last got=%b exp=1", bus.out_last); end
        tick();
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_back got=%b exp=1", bus.in_ready); end
        n_checks++; if (frame_count !== 8'd2) begin n_fail++; $display("FAIL single_frame_count got=%0d exp=2", frame_count); end
    endtask

    task automatic test_overflow();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 15; i++) push_beat(8'(i), 1'b0);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got=%b exp=0", overflow); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_ready15 got=%b exp=1", bus.in_ready); end
        push_beat(8'h0F, 1'b0);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got=%b exp=1", overflow); end
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid got=%b exp=1", bus.out_valid); end
        n_checks++; if (bus.out_data !== 8'h0F) begin n_fail++; $display("FAIL ovf_top got=%h exp=0f", bus.out_data); end
        // 17th beat offered while draining; it must wait.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h99;
        bus.in_last  = 1'b1;
        tick();
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pulse_end got=%b exp=0", overflow); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_17th_wait got=%b exp=0", bus.in_ready); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_drain_ready%0d got=%b exp=0", i, bus.in_ready); end
            n_checks++; if (bus.out_data !== 8'(15 - i)) begin n_fail++; $display("FAIL ovf_data%0d got=%h exp=%h", i, bus.out_data, 8'(15 - i)); end
            n_checks++; if (bus.out_last !== (i == 15)) begin n_fail++; $display("FAIL ovf_last%0d got=%b exp=%b", i, bus.out_last, (i == 15)); end
            tick();
        end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_ready_after got=%b exp=1", bus.in_ready); end
        n_checks++; if (frame_count !== 8'd3) begin n_fail++; $display("FAIL ovf_frame_count got=%0d exp=3", frame_count); end
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        n_checks++; if (bus.out_data !== 8'h99) begin n_fail++; $display("FAIL ovf_17th_data got=%h exp=99", bus.out_data); end
        n_checks++; if (bus.out_last !== 1'b1) begin n_fail++; $display("FAIL ovf_17th_last got=%b exp=1", bus.out_last); end
        tick();
        n_checks++; if (frame_count !== 8'd4) begin n_fail++; $display("FAIL ovf_17th_count got=%0d exp=4", frame_count); end
    endtask

    task automatic test_full_with_last();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 15; i++) push_beat(8'(8'h20 + i), 1'b0);
        push_beat(8'h2F, 1'b1);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_last_overflow got=%b exp=0", overflow); end
        n_checks++; if (bus.out_data !== 8'h2F) begin n_fail++; $display("FAIL full_last_top got=%h exp=2f", bus.out_data); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (bus.out_data !== 8'(8'h2F - i)) begin n_fail++; $display("FAIL full_last_data%0d got=%h exp=%h", i, bus.out_data, 8'(8'h2F - i)); end
            tick();
        end
        n_checks++; if (frame_count !== 8'd5) begin n_fail++; $display("FAIL full_last_count got=%0d exp=5", frame_count); end
    endtask

    task automatic test_stall();
        logic       pat   [5];
        logic [7:0] exp_d [5];
        logic       exp_l [5];
        pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_d = '{8'h63, 8'h62, 8'h62, 8'h62, 8'h61};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.out_ready = 1'b0;
        push_beat(8'h61, 1'b0);
        push_beat(8'h62, 1'b0);
        push_beat(8'h63, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bus.out_ready = pat[i];
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid%0d got=%b exp=1", i, bus.out_valid); end
            n_checks++; if (bus.out_data !== exp_d[i]) begin n_fail++; $display("FAIL stall_data%0d got=%h exp=%h", i, bus.out_data, exp_d[i]); end
            n_checks++; if (bus.out_last !== exp_l[i]) begin n_fail++; $display("FAIL stall_last%0d got=%b exp=%b", i, bus.out_last, exp_l[i]); end
            tick();
        end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_end_valid got=%b exp=0", bus.out_valid); end
        n_checks++; if (frame_count !== 8'd6) begin n_fail++; $display("FAIL stall_count got=%0d exp=6", frame_count); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp_d [2];
        exp_d = '{8'h55, 8'h44};
        bus.out_ready = 1'b1;
        push_beat(8'h71, 1'b0);
        push_beat(8'h72, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h73;
        bus.in_last  = 1'b1;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=0", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); end
        n_checks++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL midrst_count got=%0d exp=0", frame_count); end
        tick();
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready_edge got=%b exp=0", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid_edge got=%b exp=0", bus.out_valid); end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        reset = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_release got=%b exp=1", bus.in_ready); end
        push_beat(8'h44, 1'b0);
        push_beat(8'h55, 1'b1);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (bus.out_data !== exp_d[i]) begin n_fail++; $display("FAIL midrst_data%0d got=%h exp=%h", i, bus.out_data, exp_d[i]); end
            n_checks++; if (bus.out_last !== (i == 1)) begin n_fail++; $display("FAIL midrst_last%0d got=%b exp=%b", i, bus.out_last, (i == 1)); end
            tick();
        end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_end_valid got=%b exp=0", bus.out_valid); end
        n_checks++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL midrst_count_end got=%0d exp=1", frame_count); end
    endtask

    task automatic test_wrap();
        apply_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            push_beat(8'(i), 1'b1);
            tick();
            if (i == 254) begin
                n_checks++; if (frame_count !== 8'd255) begin n_fail++; $display("FAIL wrap_255 got=%0d exp=255", frame_count); end
            end
        end
        n_checks++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL wrap_0 got=%0d exp=0", frame_count); end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_single();
        test_overflow();
        test_full_with_last();
        test_stall();
        test_reset_mid_frame();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lifo_reverser.md
LIFO_REVERSER -- requirements
Module: lifo_reverser

Interface
REQ-001 Parameter DATA_BITS, default 8: width of each data beat.
REQ-002 Parameter ADDRESS_BITS, default 4: frame buffer depth is 2**ADDRESS_BITS beats.
REQ-003 clk  input  1: rising-edge clock for all state.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 in_valid  input  1: producer offers in_data this cycle.
REQ-006 in_data  input  DATA_BITS: input beat.
REQ-007 in_last  input  1: qualifies the final beat of a frame.
REQ-008 in_ready  output  1: block accepts a beat this cycle.
REQ-009 out_valid  output  1: out_data is valid.
REQ-010 out_data  output  DATA_BITS: reversed-order beat.
REQ-011 out_last  output  1: qualifies the final output beat of a frame.
REQ-012 out_ready  input  1: consumer accepts the beat this cycle.
REQ-013 overflow  output  1: one-cycle pulse when a frame is truncated at full depth.
REQ-014 frame_count  output  8: frames fully emitted since reset, wraps 255->0.

Function
REQ-015 The block SHALL run a two-state FSM: FILL (accept input) and DRAIN (emit output).
REQ-016 An input beat SHALL transfer only on a rising clk with in_valid=1 and in_ready=1; an output beat only with out_valid=1 and out_ready=1.
REQ-017 In FILL: in_ready=1 and out_valid=0. In DRAIN: in_ready=0 and out_valid=1.
REQ-018 Each accepted input beat SHALL be pushed; occupancy count (ADDRESS_BITS+1 bits) increments by 1.
REQ-019 Accepting a beat with in_last=1 SHALL move the FSM to DRAIN on the same edge.
REQ-020 Accepting a beat with in_last=0 that brings count to 2**ADDRESS_BITS SHALL move to DRAIN and pulse overflow high for exactly the following cycle; later beats start a new frame.
REQ-021 If in_last=1 coincides with reaching full depth, the transition SHALL be normal, with no overflow.
REQ-022 In DRAIN, out_data SHALL equal the most recently pushed unpopped beat; output order is the exact reverse of input order.
REQ-023 out_data SHALL be driven directly from storage indexed by registered state, so the first output beat is valid in the cycle after the last input transfer (latency 1 cycle).
REQ-024 Each output transfer SHALL pop one beat; count decrements by 1.
REQ-025 out_last SHALL be 1 exactly when in DRAIN with count==1.
REQ-026 The transfer with out_last=1 SHALL return the FSM to FILL, set count to 0, and increment frame_count modulo 256.
REQ-027 When out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-028 Input is never accepted while draining, and the block never pushes and pops in the same cycle.
REQ-029 A frame of length 1 SHALL emit one beat with out_last=1.

Reset
REQ-030 Asserting reset at any time, including mid-frame, SHALL force FILL, count=0, overflow=0, frame_count=0, out_valid=0, and out_last=0.
REQ-031 While reset=1, in_ready SHALL be 0; in_ready=1 from the first cycle after deassertion.
REQ-032 Storage contents SHALL NOT be reset; they are unobservable while count=0.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding constants (FILL, DRAIN) and default DATA_BITS/ADDRESS_BITS.
REQ-034 The storage array with push/pop pointer logic SHALL be a separate sub-module named lifo_store; the FSM, handshake and counters stay in lifo_reverser.

Verification
REQ-035 Beats 0x11, 0x22, 0x33 (last on 0x33) with out_ready=1 -> out_data 0x33, 0x22, 0x11; out_last only on 0x11; frame_count=1.
REQ-036 Single beat 0xA5 with in_last=1 -> one output 0xA5 with out_last=1 in the next cycle; in_ready returns to 1 after the transfer.
REQ-037 16 beats 0x00..0x0F with no in_last -> one overflow pulse; output 0x0F..0x00; 17th offered beat waits (in_ready=0) until drain completes.
REQ-038 Drain with out_ready toggling 1,0,0,1 -> out_data and out_last held while stalled; no beat lost or duplicated.
REQ-039 Reset asserted after 2 of 3 pushes -> in_ready=0 and out_valid=0 during reset; a new frame 0x44, 0x55 (last) then outputs 0x55, 0x44 only.
REQ-040 256 single-beat frames -> frame_count wraps to 0.
